// File: rtl/rob_commit_issuer.sv
// In-order reorder-buffer head: allocates at dispatch, completes on writeback, offers the oldest done entry.
// Optional feature macro ROB_ACK_TIMEOUT_EN: re-offer the head and raise sticky ack_timeout after TIMEOUT idle cycles.
module rob_commit_issuer #(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    parameter int ARCH_W  = 5,
    parameter int PC_W    = 32,
    parameter int CAUSE_W = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [ARCH_W-1:0]  alloc_arch,
    input  logic [PC_W-1:0]    alloc_pc,
    output logic [PTR_W-1:0]   alloc_tag,
    input  logic               wb_valid,
    input  logic [PTR_W-1:0]   wb_tag,
    input  logic               wb_exc,
    input  logic [CAUSE_W-1:0] wb_cause,
    output logic               rob_commit_valid,
    output logic [ARCH_W-1:0]  rob_commit_arch,
    output logic [PTR_W-1:0]   rob_commit_tag,
    input  logic               retire_ack,
    output logic               exception_detected,
    output logic               flush,
    output logic [PC_W-1:0]    exc_pc,
    output logic [CAUSE_W-1:0] exc_cause,
    output logic [PTR_W:0]     rob_count,
    output logic               ack_timeout
);
    localparam logic [1:0]     ST_IDLE     = 2'd0;
    localparam logic [1:0]     ST_WAIT_ACK = 2'd1;
    localparam logic [1:0]     ST_EXC      = 2'd2;
    localparam logic [PTR_W:0] FULL_CNT    = DEPTH[PTR_W:0];

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, head_nxt;
    logic [PTR_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   busy_q, busy_d, done_q, done_d, exc_q, exc_d;
    logic [ARCH_W-1:0]  arch_q [DEPTH];
    logic [ARCH_W-1:0]  arch_d [DEPTH];
    logic [PC_W-1:0]    pc_q [DEPTH];
    logic [PC_W-1:0]    pc_d [DEPTH];
    logic [CAUSE_W-1:0] cause_q [DEPTH];
    logic [CAUSE_W-1:0] cause_d [DEPTH];
    logic               cvalid_q, cvalid_d;
    logic [ARCH_W-1:0]  carch_q, carch_d;
    logic [PTR_W-1:0]   ctag_q, ctag_d;
    logic               exc_det_q, exc_det_d;
    logic [PC_W-1:0]    exc_pc_q, exc_pc_d;
    logic [CAUSE_W-1:0] exc_cause_q, exc_cause_d;
    logic               alloc_fire, pop;

`ifdef ROB_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            ack_to_q, ack_to_d;
    assign ack_timeout = ack_to_q;
`else
    assign ack_timeout = 1'b0;
`endif

    assign alloc_ready        = (count_q < FULL_CNT) && (state_q != ST_EXC);
    assign alloc_fire         = alloc_valid && alloc_ready;
    assign alloc_tag          = tail_q;
    assign head_nxt           = head_q + PTR_W'(1);
    assign rob_commit_valid   = cvalid_q;
    assign rob_commit_arch    = carch_q;
    assign rob_commit_tag     = ctag_q;
    assign exception_detected = exc_det_q;
    assign flush              = exc_det_q;
    assign exc_pc             = exc_pc_q;
    assign exc_cause          = exc_cause_q;
    assign rob_count          = count_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        busy_d      = busy_q;
        done_d      = done_q;
        exc_d       = exc_q;
        arch_d      = arch_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        cvalid_d    = 1'b0;
        carch_d     = carch_q;
        ctag_d      = ctag_q;
        exc_det_d   = 1'b0;
        exc_pc_d    = exc_pc_q;
        exc_cause_d = exc_cause_q;
        pop         = 1'b0;
`ifdef ROB_ACK_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        ack_to_d    = ack_to_q;
`endif
        // Only the first writeback to a live entry counts; the flush cycle drops all writebacks.
        if (wb_valid && (state_q != ST_EXC) && busy_q[wb_tag] && !done_q[wb_tag]) begin
            done_d[wb_tag]  = 1'b1;
            exc_d[wb_tag]   = wb_exc;
            cause_d[wb_tag] = wb_cause;
        end
        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            exc_d[tail_q]  = 1'b0;
            arch_d[tail_q] = alloc_arch;
            pc_d[tail_q]   = alloc_pc;
            tail_d         = tail_q + PTR_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (busy_q[head_q] && done_q[head_q]) begin
                    if (!exc_q[head_q]) begin
                        cvalid_d = 1'b1;
                        carch_d  = arch_q[head_q];
                        ctag_d   = head_q;
                        state_d  = ST_WAIT_ACK;
`ifdef ROB_ACK_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        exc_det_d   = 1'b1;
                        exc_pc_d    = pc_q[head_q];
                        exc_cause_d = cause_q[head_q];
                        state_d     = ST_EXC;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (retire_ack) begin
                    pop            = 1'b1;
                    busy_d[head_q] = 1'b0;
                    head_d         = head_nxt;
                    // Chain straight into the next offer when the successor is already clean and done.
                    if (busy_q[head_nxt] && done_q[head_nxt] && !exc_q[head_nxt]) begin
                        cvalid_d = 1'b1;
                        carch_d  = arch_q[head_nxt];
                        ctag_d   = head_nxt;
`ifdef ROB_ACK_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef ROB_ACK_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    ack_to_d = 1'b1;
                    cvalid_d = 1'b1;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ST_EXC: begin
                busy_d  = '0;
                done_d  = '0;
                exc_d   = '0;
                head_d  = '0;
                tail_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q == ST_EXC)       count_d = '0;
        else if (alloc_fire && !pop) count_d = count_q + (PTR_W+1)'(1);
        else if (!alloc_fire && pop) count_d = count_q - (PTR_W+1)'(1);
        else                         count_d = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            done_q      <= '0;
            exc_q       <= '0;
            cvalid_q    <= 1'b0;
            carch_q     <= '0;
            ctag_q      <= '0;
            exc_det_q   <= 1'b0;
            exc_pc_q    <= '0;
            exc_cause_q <= '0;
`ifdef ROB_ACK_TIMEOUT_EN
            to_cnt_q    <= '0;
            ack_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            cvalid_q    <= cvalid_d;
            carch_q     <= carch_d;
            ctag_q      <= ctag_d;
            exc_det_q   <= exc_det_d;
            exc_pc_q    <= exc_pc_d;
            exc_cause_q <= exc_cause_d;
`ifdef ROB_ACK_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            ack_to_q    <= ack_to_d;
`endif
        end
    end

    // Payload storage is qualified by busy/done, so it carries no reset.
    always_ff @(posedge clk) begin
        arch_q  <= arch_d;
        pc_q    <= pc_d;
        cause_q <= cause_d;
    end
endmodule

// File: tb/tb_rob_commit_issuer.sv
// Scoreboard bench for rob_commit_issuer: expected commits are queued at allocation and matched on rob_commit_valid.
module tb_rob_commit_issuer;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_arch;
    logic [31:0] alloc_pc;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic        wb_exc;
    logic [3:0]  wb_cause;
    logic        rob_commit_valid;
    logic [4:0]  rob_commit_arch;
    logic [2:0]  rob_commit_tag;
    logic        retire_ack;
    logic        exception_detected;
    logic        flush;
    logic [31:0] exc_pc;
    logic [3:0]  exc_cause;
    logic [3:0]  rob_count;
    logic        ack_timeout;

    typedef struct packed {
        logic [4:0] arch;
        logic [2:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   commit_cnt = 0;
    int   exc_cnt = 0;
    logic auto_ack = 1'b0;
    logic man_ack = 1'b0;
    logic ack_sched = 1'b0;

    rob_commit_issuer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_arch(alloc_arch),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exc(wb_exc), .wb_cause(wb_cause),
        .rob_commit_valid(rob_commit_valid), .rob_commit_arch(rob_commit_arch),
        .rob_commit_tag(rob_commit_tag), .retire_ack(retire_ack),
        .exception_detected(exception_detected), .flush(flush),
        .exc_pc(exc_pc), .exc_cause(exc_cause), .rob_count(rob_count), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            ack_sched = auto_ack && rob_commit_valid && !reset;
            if (!reset && rob_commit_valid) begin
                commit_cnt++;
                chk("commit_exc_excl", 64'(exception_detected), 64'(0));
                if (exp_q.size() == 0) begin
                    chk("commit_unexpected", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_arch", 64'(rob_commit_arch), 64'(e.arch));
                    chk("commit_tag", 64'(rob_commit_tag), 64'(e.tag));
                end
            end
            if (!reset && (exception_detected || flush)) begin
                exc_cnt++;
                chk("flush_pair", 64'(flush), 64'(exception_detected));
            end
        end
    endtask

    task automatic ack_driver();
        forever begin
            @(posedge clk);
            #2;
            retire_ack = ack_sched | man_ack;
        end
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        man_ack     = 1'b0;
        auto_ack    = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_alloc(input logic [4:0] arch, input logic [31:0] pc, input bit expect_commit);
        int i;
        for (i = 0; i < 50 && !alloc_ready; i++) tick();
        if (!alloc_ready) begin
            chk("alloc_ready_wait", 64'(alloc_ready), 64'(1));
            return;
        end
        if (expect_commit) exp_q.push_back('{arch: arch, tag: alloc_tag});
        alloc_valid = 1'b1;
        alloc_arch  = arch;
        alloc_pc    = pc;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] tag, input logic exc, input logic [3:0] cause);
        wb_valid = 1'b1;
        wb_tag   = tag;
        wb_exc   = exc;
        wb_cause = cause;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_commits(input int target);
        for (int i = 0; i < 200 && commit_cnt < target; i++) tick();
        chk("commit_cnt", 64'(commit_cnt), 64'(target));
    endtask

    task automatic wait_count(input string tag, input int target);
        for (int i = 0; i < 200 && rob_count != 4'(target); i++) tick();
        chk(tag, 64'(rob_count), 64'(target));
    endtask

    task automatic wait_valid(input string tag);
        int i;
        for (i = 0; i < 100 && !rob_commit_valid; i++) tick();
        chk(tag, 64'(rob_commit_valid), 64'(1));
    endtask

    initial begin
        int base;
        int ebase;
        reset = 1'b1; alloc_valid = 1'b0; alloc_arch = '0; alloc_pc = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_exc = 1'b0; wb_cause = '0; retire_ack = 1'b0;
        fork
            monitor();
            ack_driver();
            begin
                #200000;
                $display("FAIL watchdog: got=running expected=finished");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        reset_dut();
        chk("rst_count", 64'(rob_count), 64'(0));
        chk("rst_valid", 64'(rob_commit_valid), 64'(0));
        chk("rst_exc", 64'(exception_detected), 64'(0));
        chk("rst_flush", 64'(flush), 64'(0));
        chk("rst_tag", 64'(alloc_tag), 64'(0));
        chk("rst_exc_pc", 64'(exc_pc), 64'(0));
        chk("rst_timeout", 64'(ack_timeout), 64'(0));
        chk("rst_ready", 64'(alloc_ready), 64'(1));

        // In-order: three entries, wb in order, auto ack one cycle after each offer
        auto_ack = 1'b1;
        base = commit_cnt;
        do_alloc(5'd1, 32'h100, 1'b1);
        do_alloc(5'd2, 32'h104, 1'b1);
        do_alloc(5'd3, 32'h108, 1'b1);
        chk("inord_count3", 64'(rob_count), 64'(3));
        do_wb(3'd0, 1'b0, 4'd0);
        do_wb(3'd1, 1'b0, 4'd0);
        do_wb(3'd2, 1'b0, 4'd0);
        wait_commits(base + 3);
        wait_count("inord_drain", 0);

        // Out-of-order writeback 2,1,0: nothing commits until tag 0 completes
        reset_dut();
        auto_ack = 1'b1;
        base = commit_cnt;
        do_alloc(5'd4, 32'h200, 1'b1);
        do_alloc(5'd5, 32'h204, 1'b1);
        do_alloc(5'd6, 32'h208, 1'b1);
        do_wb(3'd2, 1'b0, 4'd0);
        repeat (3) tick();
        do_wb(3'd1, 1'b0, 4'd0);
        repeat (3) tick();
        chk("ooo_held", 64'(commit_cnt), 64'(base));
        do_wb(3'd0, 1'b0, 4'd0);
        wait_commits(base + 3);
        wait_count("ooo_drain", 0);

        // Full ROB, then same-cycle pop and allocate
        reset_dut();
        for (int i = 0; i < 8; i++) do_alloc(5'(8 + i), 32'(32'h300 + 4 * i), 1'b1);
        chk("full_count", 64'(rob_count), 64'(8));
        chk("full_ready", 64'(alloc_ready), 64'(0));
        chk("full_tail_wrap", 64'(alloc_tag), 64'(0));
        alloc_valid = 1'b1; alloc_arch = 5'd31;
        tick();
        alloc_valid = 1'b0;
        chk("full_alloc_blocked", 64'(rob_count), 64'(8));
        base = commit_cnt;
        for (int i = 0; i < 8; i++) do_wb(3'(i), 1'b0, 4'd0);
        wait_commits(base + 1);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("pop_count7", 64'(rob_count), 64'(7));
        chk("back_to_back", 64'(rob_commit_valid), 64'(1));
        chk("wrap_tag", 64'(alloc_tag), 64'(0));
        exp_q.push_back('{arch: 5'd20, tag: alloc_tag});
        man_ack = 1'b1; alloc_valid = 1'b1; alloc_arch = 5'd20; alloc_pc = 32'h400;
        tick();
        man_ack = 1'b0; alloc_valid = 1'b0;
        chk("pop_alloc_count", 64'(rob_count), 64'(7));
        auto_ack = 1'b1;
        do_wb(3'd0, 1'b0, 4'd0);
        wait_count("full_drain", 0);
        chk("full_sb_empty", 64'(exp_q.size()), 64'(0));

        // Faulting head: precise flush, tag 2 never offered
        reset_dut();
        auto_ack = 1'b1;
        ebase = exc_cnt;
        do_alloc(5'd1, 32'h100, 1'b1);
        do_alloc(5'd2, 32'h104, 1'b0);
        do_alloc(5'd3, 32'h108, 1'b0);
        do_wb(3'd0, 1'b0, 4'd0);
        wait_count("exc_after_c0", 2);
        do_wb(3'd1, 1'b1, 4'd4);
        do_wb(3'd2, 1'b0, 4'd0);
        for (int i = 0; i < 20 && !exception_detected; i++) tick();
        chk("exc_pulse", 64'(exception_detected), 64'(1));
        chk("exc_flush", 64'(flush), 64'(1));
        chk("exc_pc", 64'(exc_pc), 64'(32'h104));
        chk("exc_cause", 64'(exc_cause), 64'(4));
        chk("exc_alloc_blocked", 64'(alloc_ready), 64'(0));
        tick();
        chk("exc_pulse_end", 64'(exception_detected), 64'(0));
        chk("exc_count0", 64'(rob_count), 64'(0));
        chk("exc_ready_back", 64'(alloc_ready), 64'(1));
        repeat (8) tick();
        chk("exc_once", 64'(exc_cnt), 64'(ebase + 1));
        chk("exc_pc_held", 64'(exc_pc), 64'(32'h104));

        // Reset while waiting for ack with 5 entries
        reset_dut();
        base = commit_cnt;
        for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 32'(32'h500 + 4 * i), i == 0);
        for (int i = 0; i < 5; i++) do_wb(3'(i), 1'b0, 4'd0);
        wait_commits(base + 1);
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_count", 64'(rob_count), 64'(0));
        chk("mrst_valid", 64'(rob_commit_valid), 64'(0));
        chk("mrst_arch", 64'(rob_commit_arch), 64'(0));
        chk("mrst_ctag", 64'(rob_commit_tag), 64'(0));
        chk("mrst_atag", 64'(alloc_tag), 64'(0));
        reset = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (5) tick();
        chk("mrst_late_ack", 64'(rob_count), 64'(0));
        chk("mrst_no_commit", 64'(commit_cnt), 64'(base + 1));

        // Unacknowledged offer
        reset_dut();
        do_alloc(5'd7, 32'h600, 1'b1);
        do_wb(3'd0, 1'b0, 4'd0);
        wait_valid("noack_offer");
`ifdef ROB_ACK_TIMEOUT_EN
        exp_q.push_back('{arch: 5'd7, tag: 3'd0});
        repeat (14) tick();
        chk("to_early_flag", 64'(ack_timeout), 64'(0));
        chk("to_early_valid", 64'(rob_commit_valid), 64'(0));
        tick();
        chk("to_flag", 64'(ack_timeout), 64'(1));
        chk("to_repulse", 64'(rob_commit_valid), 64'(1));
`else
        repeat (20) tick();
        chk("noack_flag", 64'(ack_timeout), 64'(0));
        chk("noack_held", 64'(rob_count), 64'(1));
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
